// File: rtl/onchip_mem_arb_pkg.sv
// onchip_mem_arb_pkg: shared widths, requester indices and request bundle for the on-chip RAM arbiter
package onchip_mem_arb_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0] byteenable;
        logic read;
        logic write;
        logic [DATA_W-1:0] writedata;
    } req_t;
endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on contention the requester not granted last wins
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last;
    always_comb begin
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end
    // reset to 1 so m0 wins the first contention
    always_ff @(posedge clk or posedge reset)
        if (reset) last <= 1'b1;
        else if (advance) last <= grant[1];
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares the single-port on-chip RAM between two Avalon-MM masters,
// one access per cycle, read data returned to the winner one cycle after grant
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    req_t r0, r1, sel;
    logic [1:0] req, grant;
    logic rd_pend, rd_tag;
    assign r0 = '{m0_address, m0_byteenable, m0_read, m0_write, m0_writedata};
    assign r1 = '{m1_address, m1_byteenable, m1_read, m1_write, m1_writedata};
    assign req = {m1_read | m1_write, m0_read | m0_write};
    rr_arb2 u_arb (
        .clk(clk),
        .reset(reset),
        .req(req),
        .advance(|grant),
        .grant(grant)
    );
    // with no grant the m0 fields pass through; chipselect and write gate them off
    assign sel = grant[M1] ? r1 : r0;
    assign mem_address = sel.address;
    assign mem_byteenable = sel.byteenable;
    assign mem_writedata = sel.writedata;
    assign mem_chipselect = |grant;
    assign mem_write = (|grant) & sel.write;
    assign mem_clken = 1'b1;
    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];
    // read+write together executes as a write, so it must not raise readdatavalid
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag <= M0;
        end else begin
            rd_pend <= (|grant) & sel.read & ~sel.write;
            rd_tag <= grant[M1];
        end
    assign m0_readdatavalid = rd_pend & (rd_tag == M0);
    assign m1_readdatavalid = rd_pend & (rd_tag == M1);
    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;
    a_rw0: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write))
        else $warning("m0 asserted read and write together; executed as write");
    a_rw1: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write))
        else $warning("m1 asserted read and write together; executed as write");
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed stimulus with a read-response scoreboard and a behavioural
// 8192x32 byte-enabled RAM with one-cycle registered read data
module tb_onchip_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic [12:0] m0_address, m1_address, mem_address;
    logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
    logic m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;
    logic [31:0] ram [8192];

    typedef struct packed {
        logic tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_clken) begin
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            mem_readdata <= ram[mem_address];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        exp_t e;
        logic tag;
        forever begin
            @(negedge clk);
            if (!reset && (m0_readdatavalid || m1_readdatavalid)) begin
                chkb("rdv_onehot", m0_readdatavalid & m1_readdatavalid, 1'b0);
                tag = m1_readdatavalid;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rdv: got tag %0d expected no response at %0t", tag, $time);
                end else begin
                    e = sb.pop_front();
                    chkb("rdv_tag", tag, e.tag);
                    chk("readdata", tag ? m1_readdata : m0_readdata, e.data);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        {m0_address, m0_byteenable, m0_read, m0_write, m0_writedata} = '0;
        {m1_address, m1_byteenable, m1_read, m1_write, m1_writedata} = '0;
        for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
        ram[5] = 32'hDEADBEEF;
        fork monitor; join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("rst_rdv0", m0_readdatavalid, 1'b0);
        chkb("rst_rdv1", m1_readdatavalid, 1'b0);
        chkb("rst_cs", mem_chipselect, 1'b0);
        chkb("idle_wr0", m0_waitrequest, 1'b0);
        chkb("clken", mem_clken, 1'b1);
        tick;
        reset = 1'b0;
        // single read from m0
        m0_read = 1'b1; m0_address = 13'h0005;
        sb.push_back('{tag: 1'b0, data: 32'hDEADBEEF});
        @(negedge clk);
        chkb("t1_wr0", m0_waitrequest, 1'b0);
        chkb("t1_cs", mem_chipselect, 1'b1);
        chk("t1_addr", 32'(mem_address), 32'h5);
        chkb("t1_rdv0_early", m0_readdatavalid, 1'b0);
        tick;
        m0_read = 1'b0;
        @(negedge clk);
        chkb("t1_rdv0", m0_readdatavalid, 1'b1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        // simultaneous writes, m0 first after reset
        m0_write = 1'b1; m0_address = 13'h0010; m0_writedata = 32'h11111111; m0_byteenable = 4'hF;
        m1_write = 1'b1; m1_address = 13'h0011; m1_writedata = 32'h22222222; m1_byteenable = 4'hF;
        @(negedge clk);
        chkb("t2_wr0", m0_waitrequest, 1'b0);
        chkb("t2_wr1", m1_waitrequest, 1'b1);
        chkb("t2_mwrite", mem_write, 1'b1);
        chk("t2_addr0", 32'(mem_address), 32'h10);
        chk("t2_wdata0", mem_writedata, 32'h11111111);
        tick;
        m0_write = 1'b0;
        @(negedge clk);
        chkb("t2_wr1_b", m1_waitrequest, 1'b0);
        chk("t2_addr1", 32'(mem_address), 32'h11);
        chk("t2_wdata1", mem_writedata, 32'h22222222);
        tick;
        m1_write = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1;
        sb.push_back('{tag: 1'b0, data: 32'h11111111});
        sb.push_back('{tag: 1'b1, data: 32'h22222222});
        @(negedge clk);
        chkb("t2_rd_wr1", m1_waitrequest, 1'b1);
        tick;
        m0_read = 1'b0;
        tick;
        m1_read = 1'b0;
        // continuous contention alternates grants
        m0_read = 1'b1; m1_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{tag: 1'b0, data: 32'h11111111});
            sb.push_back('{tag: 1'b1, data: 32'h22222222});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chkb("t3_wr0", m0_waitrequest, 1'(i % 2));
            chk("t3_addr", 32'(mem_address), (i % 2) ? 32'h11 : 32'h10);
            tick;
        end
        m0_read = 1'b0; m1_read = 1'b0;
        // partial byte write, then read-back next cycle
        m0_write = 1'b1; m0_address = 13'h0020; m0_byteenable = 4'h2; m0_writedata = 32'hAABBCCDD;
        tick;
        m0_write = 1'b0; m0_read = 1'b1;
        sb.push_back('{tag: 1'b0, data: 32'h0000CC00});
        tick;
        m0_read = 1'b0;
        // reset kills a pending m1 response
        m1_read = 1'b1; m1_address = 13'h0005;
        @(negedge clk);
        chkb("t5_wr1", m1_waitrequest, 1'b0);
        tick;
        m1_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        chkb("t5_rdv1_killed", m1_readdatavalid, 1'b0);
        tick;
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 13'h0005; m1_read = 1'b1;
        sb.push_back('{tag: 1'b0, data: 32'hDEADBEEF});
        sb.push_back('{tag: 1'b1, data: 32'hDEADBEEF});
        @(negedge clk);
        chkb("t5_post_wr0", m0_waitrequest, 1'b0);
        chkb("t5_post_wr1", m1_waitrequest, 1'b1);
        tick;
        m0_read = 1'b0;
        tick;
        m1_read = 1'b0;
        // illegal read+write executes as a write with no response
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 13'h0030; m1_writedata = 32'h5A5A5A5A;
        m1_byteenable = 4'hF;
        @(negedge clk);
        chkb("t6_mwrite", mem_write, 1'b1);
        chkb("t6_wr1", m1_waitrequest, 1'b0);
        tick;
        m1_read = 1'b0; m1_write = 1'b0;
        @(negedge clk);
        chkb("t6_no_rdv1", m1_readdatavalid, 1'b0);
        tick;
        m0_read = 1'b1; m0_address = 13'h0030;
        sb.push_back('{tag: 1'b0, data: 32'h5A5A5A5A});
        tick;
        m0_read = 1'b0;
        repeat (3) tick;
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
